// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style instruction path.
// Holds the instruction width, opcode/funct constants, the instruction-field
// positions used by the fetch unit and the fetch FSM state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;

    // Field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Jump target: {pc_plus4[ADDR_W-1:J_PC_HI_LSB], instr[J_IDX_MSB:J_IDX_LSB], 2'b00}
    localparam int J_IDX_MSB   = 25;
    localparam int J_IDX_LSB   = 0;
    localparam int J_PC_HI_LSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Two-entry {instr, pc} queue between instruction memory and decode.
// Slot 0 is always the head, so the head outputs come straight from registers.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   push, push_instr/pc     write an entry (ignored when full and not popping)
//   pop                     remove head (ignored when empty)
//   flush                   empty the queue; overrides push and pop
//   head_instr, head_pc     current head entry
//   full, empty             occupancy flags
module instr_fifo
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic               full,
    output logic               empty
);

    logic [INSTR_W-1:0] instr0_q, instr1_q;
    logic [ADDR_W-1:0]  pc0_q, pc1_q;
    logic [1:0]         cnt_q;
    logic               do_push, do_pop;

    assign do_pop  = pop & (cnt_q != 2'd0);
    // A full queue still accepts a word when the head leaves on the same edge.
    assign do_push = push & ((cnt_q != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        instr0_q <= push_instr;
                        pc0_q    <= push_pc;
                    end else begin
                        instr1_q <= push_instr;
                        pc1_q    <= push_pc;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    instr0_q <= instr1_q;
                    pc0_q    <= pc1_q;
                    cnt_q    <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (cnt_q == 2'd1) begin
                        instr0_q <= push_instr;
                        pc0_q    <= push_pc;
                    end else begin
                        instr0_q <= instr1_q;
                        pc0_q    <= pc1_q;
                        instr1_q <= push_instr;
                        pc1_q    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_instr = instr0_q;
    assign head_pc    = pc0_q;
    assign full       = (cnt_q == 2'd2);
    assign empty      = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues PC-sequenced reads to instruction memory,
// buffers returned words in a 2-entry queue and presents the head to decode.
// A jump reported by the consumer flushes the queue and redirects the PC;
// a response already in flight at that moment is discarded.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr              read request, held with stable address until ack
//   imem_ack/imem_rdata             one-cycle response pulse with data
//   instr_valid/instr_ready         head handshake with the consumer
//   instr, op_code, funct, instr_pc head word, its opcode/funct slices and address
//   jump_taken                      accepted head is a jump (qualified by handshake)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op_code,
    output logic [5:0]         funct,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jump_taken
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_HI_MASK = ~ADDR_W'((64'd1 << J_PC_HI_LSB) - 64'd1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;

    logic              accept, jump, push;
    logic              fifo_full, fifo_empty;
    logic [1:0]        occ, occ_next;
    logic              room;
    logic [ADDR_W-1:0] pc_plus4, target;

    assign accept = instr_valid & instr_ready;
    assign jump   = accept & jump_taken;
    // Only a response to a live FETCH request is kept; a jump on the ack edge kills it.
    assign push   = (state_q == ST_FETCH) & req_q & imem_ack & ~jump;

    assign pc_plus4 = instr_pc + PC_STEP;
    assign target   = (pc_plus4 & PC_HI_MASK) | ADDR_W'({instr[J_IDX_MSB:J_IDX_LSB], 2'b00});

    // Queue occupancy after this edge; a new request may only go out if a slot
    // will still be free for its response.
    assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ_next = jump ? 2'd0 : (occ + {1'b0, push} - {1'b0, accept});
    assign room     = (occ_next != 2'd2);

    instr_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (fetch_pc_q),
        .pop        (accept),
        .flush      (jump),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        if (jump) begin
            fetch_pc_d = target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (req_q) begin
                    if (imem_ack) begin
                        // Always leave a request-free cycle after an ack.
                        req_d   = 1'b0;
                        state_d = room ? ST_FETCH : ST_HOLD;
                    end else if (jump) begin
                        // Address must stay on the old request until it completes.
                        state_d = ST_DROP;
                    end
                end else if (room) begin
                    req_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (room) begin
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Address is captured only when a new request is raised, so it stays
    // stable for the whole request even if the PC is redirected meanwhile.
    assign addr_d = (!req_q && req_d) ? fetch_pc_d : addr_q;

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = ~fifo_empty;
    assign op_code     = instr[OP_MSB:OP_LSB];
    assign funct       = instr[FUNCT_MSB:FUNCT_LSB];

endmodule
